// File: rtl/board_io_sequencer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | board_io_pkg                                                             |
// | Shared boot-state type and parameter range check for board_io_sequencer. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package board_io_pkg;

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      RST_HOLD  = 2'd1,
      FETCH_DLY = 2'd2,
      RUN       = 2'd3
   } boot_state_e;

   function automatic bit params_ok(
      input int num_gpio,
      input int sync_stages,
      input int deb_tick_div,
      input int deb_ticks,
      input int rst_hold_cycles,
      input int fetch_delay_cycles
   );
      return (num_gpio >= 1) && (num_gpio <= 32) && (sync_stages >= 2) &&
             (deb_tick_div >= 2) && (deb_ticks >= 1) &&
             (rst_hold_cycles >= 1) && (fetch_delay_cycles >= 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/board_io_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | board_io_sequencer_if                                                    |
// | Boot control and GPIO pad bundle between board top, sequencer and SoC.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface board_io_sequencer_if #(
   parameter int NUM_GPIO = 32
);
   import board_io_pkg::*;

   logic                pll_locked_i;
   logic                fetch_enable_i;
   logic                soc_rst_no;
   logic                fetch_enable_o;
   boot_state_e         boot_state_o;
   logic [NUM_GPIO-1:0] gpio_pad_i;
   logic [NUM_GPIO-1:0] deb_en_i;
   logic [NUM_GPIO-1:0] gpio_in_o;
   logic [NUM_GPIO-1:0] gpio_rise_o;
   logic [NUM_GPIO-1:0] gpio_fall_o;
   logic [NUM_GPIO-1:0] gpio_out_i;
   logic [NUM_GPIO-1:0] gpio_dir_i;
   logic [NUM_GPIO-1:0] gpio_pad_o;
   logic [NUM_GPIO-1:0] gpio_pad_t_o;

   modport slave (
      input  pll_locked_i, fetch_enable_i, gpio_pad_i, deb_en_i, gpio_out_i, gpio_dir_i,
      output soc_rst_no, fetch_enable_o, boot_state_o, gpio_in_o, gpio_rise_o,
             gpio_fall_o, gpio_pad_o, gpio_pad_t_o
   );

   modport master (
      output pll_locked_i, fetch_enable_i, gpio_pad_i, deb_en_i, gpio_out_i, gpio_dir_i,
      input  soc_rst_no, fetch_enable_o, boot_state_o, gpio_in_o, gpio_rise_o,
             gpio_fall_o, gpio_pad_o, gpio_pad_t_o
   );

endinterface
`default_nettype wire

// File: rtl/board_io_sequencer_debounce.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gpio_debounce_ch                                                         |
// | One GPIO channel: tick-based debounce of a synchronised level + edges.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module gpio_debounce_ch #(
   parameter int DEB_TICKS = 4
) (
   input  wire logic clk,
   input  wire logic rst_n,
   input  wire logic i_sync,
   input  wire logic i_tick,
   input  wire logic i_deb_en,
   output logic      o_level,
   output logic      o_rise,
   output logic      o_fall
);

   localparam int                 c_cnt_w    = $clog2(DEB_TICKS + 1);
   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEB_TICKS - 1);
   localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

   logic [c_cnt_w-1:0] r_cnt;
   logic               r_level;
   logic               r_level_d;
   logic               r_rise;
   logic               r_fall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt     <= '0;
         r_level   <= 1'b0;
         r_level_d <= 1'b0;
         r_rise    <= 1'b0;
         r_fall    <= 1'b0;
      end else begin
         r_level_d <= r_level;
         r_rise    <= r_level & ~r_level_d;
         r_fall    <= ~r_level & r_level_d;
         if (!i_deb_en) begin
            r_level <= i_sync;
            r_cnt   <= '0;
         end else if (i_sync == r_level) begin
            r_cnt <= '0;
         end else if (i_tick) begin
            // The tick that brings the count to DEB_TICKS accepts the new level
            if (r_cnt >= c_cnt_last) begin
               r_level <= i_sync;
               r_cnt   <= '0;
            end else begin
               r_cnt <= r_cnt + c_cnt_one;
            end
         end
      end
   end

   assign o_level = r_level;
   assign o_rise  = r_rise;
   assign o_fall  = r_fall;

endmodule
`default_nettype wire

// File: rtl/board_io_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | board_io_sequencer                                                       |
// | SoC reset/fetch boot sequencing from PLL lock plus GPIO pad conditioning.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module board_io_sequencer
   import board_io_pkg::*;
#(
   parameter int NUM_GPIO           = 32,
   parameter int SYNC_STAGES        = 2,
   parameter int DEB_TICK_DIV       = 500,
   parameter int DEB_TICKS          = 4,
   parameter int RST_HOLD_CYCLES    = 1024,
   parameter int FETCH_DELAY_CYCLES = 256
) (
   input wire logic            clk,
   input wire logic            rst_n,
   board_io_sequencer_if.slave io
);

   if (!params_ok(NUM_GPIO, SYNC_STAGES, DEB_TICK_DIV, DEB_TICKS,
                  RST_HOLD_CYCLES, FETCH_DELAY_CYCLES)) begin : g_param_check
      $error("board_io_sequencer: parameter out of range");
   end

   localparam int c_sync_w = NUM_GPIO + 2;
   localparam int c_pre_w  = $clog2(DEB_TICK_DIV);
   localparam int c_cnt_max = (RST_HOLD_CYCLES > FETCH_DELAY_CYCLES) ?
                              RST_HOLD_CYCLES : FETCH_DELAY_CYCLES;
   localparam int c_cnt_w  = $clog2(c_cnt_max + 1);

   localparam logic [c_pre_w-1:0] c_pre_last   = c_pre_w'(DEB_TICK_DIV - 1);
   localparam logic [c_pre_w-1:0] c_pre_one    = c_pre_w'(1);
   localparam logic [c_cnt_w-1:0] c_hold_last  = c_cnt_w'(RST_HOLD_CYCLES - 1);
   localparam logic [c_cnt_w-1:0] c_fetch_last = c_cnt_w'(FETCH_DELAY_CYCLES - 1);
   localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);

   logic [c_sync_w-1:0] r_sync [SYNC_STAGES];
   logic [NUM_GPIO-1:0] w_gpio_s;
   logic                w_lock_s;
   logic                w_fetch_s;
   logic [c_pre_w-1:0]  r_pre;
   logic                w_tick;
   boot_state_e         r_state;
   logic [c_cnt_w-1:0]  r_cnt;
   logic                r_soc_rst_n;
   logic                r_fetch_en;
   logic [NUM_GPIO-1:0] r_pad_o;
   logic [NUM_GPIO-1:0] r_pad_t;
   logic [NUM_GPIO-1:0] w_gpio_in;
   logic [NUM_GPIO-1:0] w_gpio_rise;
   logic [NUM_GPIO-1:0] w_gpio_fall;

   // All asynchronous inputs share one synchroniser chain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      end else begin
         r_sync[0] <= {io.fetch_enable_i, io.pll_locked_i, io.gpio_pad_i};
         for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      end
   end

   assign w_gpio_s  = r_sync[SYNC_STAGES-1][NUM_GPIO-1:0];
   assign w_lock_s  = r_sync[SYNC_STAGES-1][NUM_GPIO];
   assign w_fetch_s = r_sync[SYNC_STAGES-1][NUM_GPIO+1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pre <= '0;
      end else if (r_pre == c_pre_last) begin
         r_pre <= '0;
      end else begin
         r_pre <= r_pre + c_pre_one;
      end
   end

   assign w_tick = (r_pre == c_pre_last);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= WAIT_LOCK;
         r_cnt       <= '0;
         r_soc_rst_n <= 1'b0;
         r_fetch_en  <= 1'b0;
      end else begin
         r_cnt       <= r_cnt + c_cnt_one;
         // Gating on lock_s drops both outputs in the same cycle the state falls back
         r_soc_rst_n <= w_lock_s && ((r_state == FETCH_DLY) || (r_state == RUN));
         r_fetch_en  <= w_lock_s && (r_state == RUN) && w_fetch_s;
         if (!w_lock_s) begin
            r_state <= WAIT_LOCK;
            r_cnt   <= '0;
         end else begin
            case (r_state)
               WAIT_LOCK: begin
                  r_state <= RST_HOLD;
                  r_cnt   <= '0;
               end
               RST_HOLD: begin
                  if (r_cnt == c_hold_last) begin
                     r_state <= FETCH_DLY;
                     r_cnt   <= '0;
                  end
               end
               FETCH_DLY: begin
                  if (r_cnt == c_fetch_last) begin
                     r_state <= RUN;
                     r_cnt   <= '0;
                  end
               end
               RUN: begin
                  r_cnt <= '0;
               end
               default: begin
                  r_state <= WAIT_LOCK;
                  r_cnt   <= '0;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pad_o <= '0;
         r_pad_t <= '1;
      end else begin
         r_pad_o <= io.gpio_out_i;
         r_pad_t <= ~io.gpio_dir_i | {NUM_GPIO{~r_soc_rst_n}};
      end
   end

   for (genvar g = 0; g < NUM_GPIO; g++) begin : g_gpio
      gpio_debounce_ch #(
         .DEB_TICKS (DEB_TICKS)
      ) u_ch (
         .clk      (clk),
         .rst_n    (rst_n),
         .i_sync   (w_gpio_s[g]),
         .i_tick   (w_tick),
         .i_deb_en (io.deb_en_i[g]),
         .o_level  (w_gpio_in[g]),
         .o_rise   (w_gpio_rise[g]),
         .o_fall   (w_gpio_fall[g])
      );
   end

   assign io.soc_rst_no     = r_soc_rst_n;
   assign io.fetch_enable_o = r_fetch_en;
   assign io.boot_state_o   = r_state;
   assign io.gpio_in_o      = w_gpio_in;
   assign io.gpio_rise_o    = w_gpio_rise;
   assign io.gpio_fall_o    = w_gpio_fall;
   assign io.gpio_pad_o     = r_pad_o;
   assign io.gpio_pad_t_o   = r_pad_t;

endmodule
`default_nettype wire
